// File: rtl/queue_ptr_ctrl.sv
// queue_ptr_ctrl: pointer/occupancy controller for circular in-order queues.
// Tracks valid bits, front (next alloc) and back (oldest) pointers with wrap
// bits, multi-wide allocate/retire, and flush recovery with an allocation
// blackout window. Optional squash statistics: QPTR_FLUSH_STATS_EN.
module queue_ptr_ctrl #(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned ALLOC_W     = 2,
  parameter int unsigned RETIRE_W    = 2,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(ALLOC_W+1)-1:0]  alloc_cnt,
  output logic                          alloc_ok,
  output logic [$clog2(SIZE)-1:0]       alloc_idx,
  input  logic [$clog2(RETIRE_W+1)-1:0] retire_cnt,
  input  logic [SIZE-1:0]               flush_vec,
  output logic [$clog2(SIZE)-1:0]       front_ptr,
  output logic [$clog2(SIZE)-1:0]       back_ptr,
  output logic [SIZE-1:0]               valid,
  output logic [$clog2(SIZE):0]         count,
  output logic                          full,
  output logic                          empty,
  output logic                          flush_change,
  output logic                          recovering,
  output logic [31:0]                   flushed_total
);

  localparam int unsigned PTR_W = $clog2(SIZE);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RC_W  = (RECOVER_CYC > 0) ? $clog2(RECOVER_CYC + 1) : 1;

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t            state;
  logic [RC_W-1:0]   rcnt;
  logic              front_wrap, back_wrap;

  logic [SIZE-1:0]   hit;
  logic              flush;
  logic              found;
  logic [PTR_W-1:0]  f_age;
  logic [PTR_W-1:0]  idx;
  logic [CNT_W-1:0]  free_cnt, k, r_eff;
  logic [CNT_W-1:0]  back_sum, front_sum;
  logic [PTR_W-1:0]  front_nxt, back_nxt;
  logic              front_wrap_nxt, back_wrap_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [SIZE-1:0]   valid_nxt;
  logic [PTR_W-1:0]  age_i, fofs_i;

  assign alloc_idx  = front_ptr;
  assign full       = (front_ptr == back_ptr) && (front_wrap != back_wrap);
  assign empty      = (front_ptr == back_ptr) && (front_wrap == back_wrap);
  assign recovering = (state == RECOVER);

  // Oldest squashed entry: scan in age order starting from back.
  always_comb begin
    hit   = flush_vec & valid;
    flush = |hit;
    found = 1'b0;
    f_age = '0;
    idx   = '0;
    for (int unsigned a = 0; a < SIZE; a++) begin
      idx = back_ptr + PTR_W'(a);
      if (!found && hit[idx]) begin
        found = 1'b1;
        f_age = PTR_W'(a);
      end
    end
  end

  // Allocation gate, effective retire, and next pointer/count/valid state.
  always_comb begin
    free_cnt = CNT_W'(SIZE) - count;
    alloc_ok = (state == IDLE) && !flush && (free_cnt >= CNT_W'(alloc_cnt));
    k        = alloc_ok ? CNT_W'(alloc_cnt) : '0;

    r_eff = CNT_W'(retire_cnt);
    if (r_eff > count) r_eff = count;
    if (flush && (r_eff > {1'b0, f_age})) r_eff = {1'b0, f_age};

    back_sum      = {1'b0, back_ptr} + r_eff;
    back_nxt      = back_sum[PTR_W-1:0];
    back_wrap_nxt = back_wrap ^ back_sum[PTR_W];

    if (flush) begin
      front_sum = {1'b0, back_ptr} + {1'b0, f_age};
      count_nxt = {1'b0, f_age} - r_eff;
    end else begin
      front_sum = {1'b0, front_ptr} + k;
      count_nxt = count + k - r_eff;
    end
    front_nxt      = front_sum[PTR_W-1:0];
    front_wrap_nxt = flush ? (back_wrap ^ front_sum[PTR_W])
                           : (front_wrap ^ front_sum[PTR_W]);

    valid_nxt = valid;
    age_i     = '0;
    fofs_i    = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      age_i  = PTR_W'(i) - back_ptr;
      fofs_i = PTR_W'(i) - front_ptr;
      if ({1'b0, age_i} < r_eff) valid_nxt[i] = 1'b0;
      if (flush && (age_i >= f_age)) valid_nxt[i] = 1'b0;
      if ({1'b0, fofs_i} < k) valid_nxt[i] = 1'b1;
    end
  end

  // Pointer state, flush pulse and recovery FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_ptr    <= '0;
      back_ptr     <= '0;
      front_wrap   <= 1'b0;
      back_wrap    <= 1'b0;
      valid        <= '0;
      count        <= '0;
      flush_change <= 1'b0;
      state        <= IDLE;
      rcnt         <= '0;
    end else begin
      front_ptr    <= front_nxt;
      back_ptr     <= back_nxt;
      front_wrap   <= front_wrap_nxt;
      back_wrap    <= back_wrap_nxt;
      valid        <= valid_nxt;
      count        <= count_nxt;
      flush_change <= flush;
      if (flush && (RECOVER_CYC > 0)) begin
        state <= RECOVER;
        rcnt  <= RC_W'(RECOVER_CYC);
      end else if (state == RECOVER) begin
        if (rcnt <= RC_W'(1)) state <= IDLE;
        rcnt <= rcnt - RC_W'(1);
      end
    end
  end

`ifdef QPTR_FLUSH_STATS_EN
  logic [CNT_W-1:0] squashed;
  logic [32:0]      total_sum;

  // Squashed-entry count for this edge, saturating accumulation.
  always_comb begin
    squashed  = flush ? (count - {1'b0, f_age}) : '0;
    total_sum = {1'b0, flushed_total} + 33'(squashed);
  end

  // Saturating flush statistics counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               flushed_total <= '0;
    else if (total_sum[32]) flushed_total <= '1;
    else                   flushed_total <= total_sum[31:0];
  end
`else
  assign flushed_total = '0;
`endif

endmodule

// File: tb/tb_queue_ptr_ctrl.sv
// Directed table-driven bench for queue_ptr_ctrl (SIZE=8, ALLOC_W=2,
// RETIRE_W=2, RECOVER_CYC=2), plus an asynchronous reset sequence.
module tb_queue_ptr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alloc_cnt;
  logic        alloc_ok;
  logic [2:0]  alloc_idx;
  logic [1:0]  retire_cnt;
  logic [7:0]  flush_vec;
  logic [2:0]  front_ptr, back_ptr;
  logic [7:0]  valid;
  logic [3:0]  count;
  logic        full, empty, flush_change, recovering;
  logic [31:0] flushed_total;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int          row      = -1;

  queue_ptr_ctrl #(
    .SIZE(8), .ALLOC_W(2), .RETIRE_W(2), .RECOVER_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .alloc_cnt(alloc_cnt), .alloc_ok(alloc_ok),
    .alloc_idx(alloc_idx), .retire_cnt(retire_cnt), .flush_vec(flush_vec),
    .front_ptr(front_ptr), .back_ptr(back_ptr), .valid(valid), .count(count),
    .full(full), .empty(empty), .flush_change(flush_change),
    .recovering(recovering), .flushed_total(flushed_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ac;
    logic [1:0]  rc;
    logic [7:0]  fv;
    logic        ok;   // alloc_ok before the edge
    logic [2:0]  fr;
    logic [2:0]  bk;
    logic [7:0]  vl;
    logic [3:0]  cn;
    logic        fu;
    logic        em;
    logic        fc;
    logic        rec;
    int unsigned ft;   // flushed_total when statistics are built
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] ac, logic [1:0] rc, logic [7:0] fv,
                              logic ok, logic [2:0] fr, logic [2:0] bk,
                              logic [7:0] vl, logic [3:0] cn, logic fu,
                              logic em, logic fc, logic rec, int unsigned ft);
    vec_t v;
    v.ac = ac; v.rc = rc; v.fv = fv; v.ok = ok; v.fr = fr; v.bk = bk;
    v.vl = vl; v.cn = cn; v.fu = fu; v.em = em; v.fc = fc; v.rec = rec;
    v.ft = ft;
    return v;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", nm, row, act, exp);
    end
  endtask

  function automatic int unsigned exp_ft(input int unsigned ft);
`ifdef QPTR_FLUSH_STATS_EN
    return ft;
`else
    return ft * 0;
`endif
  endfunction

  task automatic chk_regs(input vec_t v);
    chk("front_ptr", front_ptr, v.fr);
    chk("alloc_idx", alloc_idx, v.fr);
    chk("back_ptr", back_ptr, v.bk);
    chk("valid", valid, v.vl);
    chk("count", count, v.cn);
    chk("full", full, v.fu);
    chk("empty", empty, v.em);
    chk("flush_change", flush_change, v.fc);
    chk("recovering", recovering, v.rec);
    chk("flushed_total", flushed_total, exp_ft(v.ft));
  endtask

  initial begin
    vec_t v;
    // ac rc fv     ok fr bk vl     cn fu em fc rec ft
    tbl.push_back(mk(2, 0, 8'h00, 1, 2, 0, 8'h03, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 8'h00, 1, 4, 0, 8'h0F, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 8'h00, 1, 6, 0, 8'h3F, 6, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 8'h00, 1, 0, 0, 8'hFF, 8, 1, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 8'h00, 0, 0, 0, 8'hFF, 8, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h10, 0, 4, 0, 8'h0F, 4, 0, 0, 1, 1, 4));
    tbl.push_back(mk(2, 0, 8'h00, 0, 4, 0, 8'h0F, 4, 0, 0, 0, 1, 4));
    tbl.push_back(mk(2, 0, 8'h00, 0, 4, 0, 8'h0F, 4, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 8'h00, 1, 5, 0, 8'h1F, 5, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 2, 8'h00, 1, 6, 2, 8'h3C, 4, 0, 0, 0, 0, 4));
    tbl.push_back(mk(2, 2, 8'h00, 1, 0, 4, 8'hF0, 4, 0, 0, 0, 0, 4));
    tbl.push_back(mk(2, 2, 8'h00, 1, 2, 6, 8'hC3, 4, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 8'h81, 0, 7, 6, 8'h40, 1, 0, 0, 1, 1, 7));
    tbl.push_back(mk(0, 0, 8'h00, 0, 7, 6, 8'h40, 1, 0, 0, 0, 1, 7));
    tbl.push_back(mk(0, 0, 8'h00, 0, 7, 6, 8'h40, 1, 0, 0, 0, 0, 7));
    tbl.push_back(mk(2, 0, 8'h00, 1, 1, 6, 8'hC1, 3, 0, 0, 0, 0, 7));
    tbl.push_back(mk(0, 2, 8'h80, 0, 7, 7, 8'h00, 0, 0, 1, 1, 1, 9));
    tbl.push_back(mk(0, 0, 8'h00, 0, 7, 7, 8'h00, 0, 0, 1, 0, 1, 9));
    tbl.push_back(mk(0, 2, 8'h00, 0, 7, 7, 8'h00, 0, 0, 1, 0, 0, 9));
    tbl.push_back(mk(2, 0, 8'h00, 1, 1, 7, 8'h81, 2, 0, 0, 0, 0, 9));
    tbl.push_back(mk(2, 0, 8'h00, 1, 3, 7, 8'h87, 4, 0, 0, 0, 0, 9));
    tbl.push_back(mk(0, 0, 8'h02, 0, 1, 7, 8'h81, 2, 0, 0, 1, 1, 11));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 7, 8'h81, 2, 0, 0, 0, 1, 11));
    tbl.push_back(mk(0, 0, 8'h01, 0, 0, 7, 8'h80, 1, 0, 0, 1, 1, 12));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 7, 8'h80, 1, 0, 0, 0, 1, 12));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 7, 8'h80, 1, 0, 0, 0, 0, 12));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 7, 8'h81, 2, 0, 0, 0, 0, 12));
    tbl.push_back(mk(0, 0, 8'h01, 0, 0, 7, 8'h80, 1, 0, 0, 1, 1, 13));

    rst = 1'b1; alloc_cnt = '0; retire_cnt = '0; flush_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    v = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    chk_regs(v);
    chk("alloc_ok", alloc_ok, 1);
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      row = n;
      v = tbl[n];
      alloc_cnt = v.ac; retire_cnt = v.rc; flush_vec = v.fv;
      @(negedge clk);
      chk("alloc_ok", alloc_ok, v.ok);
      @(posedge clk);
      #1;
      alloc_cnt = '0; retire_cnt = '0; flush_vec = '0;
      chk_regs(v);
    end

    // Asynchronous reset in the middle of the recovery window.
    row = 100;
    #2;
    chk("recovering_pre_rst", recovering, 1);
    rst = 1'b1;
    #1;
    v = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    chk_regs(v);
    chk("alloc_ok", alloc_ok, 1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("count_after_rst", count, 0);
    chk("empty_after_rst", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
